// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared constants and helpers for the hardwired control sequencer
package cpu_ctrl_pkg;

    localparam int OPW  = 5;
    localparam int NREG = 16;
    localparam int RW   = 4;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [OPW-1:0] OP_ADD   = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB   = 5'b00100;
    localparam logic [OPW-1:0] OP_AND   = 5'b00101;
    localparam logic [OPW-1:0] OP_OR    = 5'b00110;
    localparam logic [OPW-1:0] OP_MUL   = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV   = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG   = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT   = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP   = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT  = 5'b11011;
    localparam logic [OPW-1:0] OP_INCPC = 5'b11111;

    typedef logic [3:0] state_t;

    localparam state_t S_RST    = 4'd0;
    localparam state_t S_T0     = 4'd1;
    localparam state_t S_T1     = 4'd2;
    localparam state_t S_T2     = 4'd3;
    localparam state_t S_T3     = 4'd4;
    localparam state_t S_T4     = 4'd5;
    localparam state_t S_T5     = 4'd6;
    localparam state_t S_T6     = 4'd7;
    localparam state_t S_HALTED = 4'd8;

    function automatic logic [NREG-1:0] onehot16(input logic [RW-1:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// rtl/ir_field_decode.sv - splits IR into opcode/register fields and instruction-class flags
module ir_field_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]    ir,
    output logic [OPW-1:0] op,
    output logic [RW-1:0]  ra,
    output logic [RW-1:0]  rb,
    output logic [RW-1:0]  rc,
    output logic           is_alu3,
    output logic           is_unary,
    output logic           is_muldiv,
    output logic           is_nop,
    output logic           is_halt,
    output logic           is_illegal
);

    logic unused_low_bits;

    assign op = ir[OP_MSB:OP_LSB];
    assign ra = ir[RA_MSB:RA_LSB];
    assign rb = ir[RB_MSB:RB_LSB];
    assign rc = ir[RC_MSB:RC_LSB];

    // Immediate/offset bits belong to the datapath, not to sequencing.
    assign unused_low_bits = ^ir[RC_LSB-1:0];

    always_comb begin
        is_alu3   = 1'b0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: is_alu3   = 1'b1;
            OP_NEG, OP_NOT:                is_unary  = 1'b1;
            OP_MUL, OP_DIV:                is_muldiv = 1'b1;
            OP_NOP:                        is_nop    = 1'b1;
            OP_HALT:                       is_halt   = 1'b1;
            default: ;
        endcase
    end

    // INCPC is an ALU-internal code, so as an instruction it counts as undefined.
    assign is_illegal = !(is_alu3 || is_unary || is_muldiv || is_nop || is_halt);

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Moore fetch/decode/execute control unit; ILLEGAL_TRAP_EN adds illegal-opcode trap
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic [OPW-1:0]  alu_op,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_out,
    output logic            PCout,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            MDRout,
    output logic            PCin,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            ZlowIn,
    output logic            ZhighIn,
    output logic            HIin,
    output logic            LOin,
    output logic            Read,
    output logic            run
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic            illegal_op
`endif
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op;
    logic [RW-1:0]  ra;
    logic [RW-1:0]  rb;
    logic [RW-1:0]  rc;
    logic           is_alu3;
    logic           is_unary;
    logic           is_muldiv;
    logic           is_nop;
    logic           is_halt;
    logic           is_illegal;

    ir_field_decode u_decode (
        .ir         (ir),
        .op         (op),
        .ra         (ra),
        .rb         (rb),
        .rc         (rc),
        .is_alu3    (is_alu3),
        .is_unary   (is_unary),
        .is_muldiv  (is_muldiv),
        .is_nop     (is_nop),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            // PC reload repeats harmlessly while memory is still busy.
            S_T1:  state_d = mem_ready ? S_T2 : S_T1;
            S_T2:  state_d = S_T3;
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALTED;
                end else if (is_alu3 || is_unary || is_muldiv) begin
                    state_d = S_T4;
                end else if (is_nop) begin
                    state_d = S_T0;
                end
`ifdef ILLEGAL_TRAP_EN
                else if (is_illegal) begin
                    state_d = S_HALTED;
                end
`endif
                else begin
                    state_d = S_T0;
                end
            end
            S_T4:     state_d = (is_alu3 || is_muldiv) ? S_T5 : S_T0;
            S_T5:     state_d = is_muldiv ? S_T6 : S_T0;
            S_T6:     state_d = S_T0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RST;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_T3 && is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    logic unused_illegal;

    assign unused_illegal = is_illegal;
`endif

    always_comb begin
        alu_op   = '0;
        reg_in   = '0;
        reg_out  = '0;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZlowIn   = 1'b0;
        ZhighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        run      = (state_q != S_HALTED);
        case (state_q)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                ZlowIn = 1'b1;
                alu_op = OP_INCPC;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu3) begin
                    reg_out = onehot16(rb);
                    Yin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = onehot16(ra);
                    Yin     = 1'b1;
                end else if (is_unary) begin
                    reg_out = onehot16(rb);
                    ZlowIn  = 1'b1;
                    alu_op  = op;
                end
            end
            S_T4: begin
                if (is_alu3) begin
                    reg_out = onehot16(rc);
                    ZlowIn  = 1'b1;
                    alu_op  = op;
                end else if (is_unary) begin
                    Zlowout = 1'b1;
                    reg_in  = onehot16(ra);
                end else if (is_muldiv) begin
                    reg_out = onehot16(rb);
                    ZlowIn  = 1'b1;
                    ZhighIn = 1'b1;
                    alu_op  = op;
                end
            end
            S_T5: begin
                if (is_alu3) begin
                    Zlowout = 1'b1;
                    reg_in  = onehot16(ra);
                end else if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer against a per-instruction cycle model
module tb_control_sequencer;

    localparam logic [4:0] T_ADD   = 5'b00011;
    localparam logic [4:0] T_SUB   = 5'b00100;
    localparam logic [4:0] T_AND   = 5'b00101;
    localparam logic [4:0] T_OR    = 5'b00110;
    localparam logic [4:0] T_MUL   = 5'b01111;
    localparam logic [4:0] T_DIV   = 5'b10000;
    localparam logic [4:0] T_NEG   = 5'b10001;
    localparam logic [4:0] T_NOT   = 5'b10010;
    localparam logic [4:0] T_NOP   = 5'b11010;
    localparam logic [4:0] T_HALT  = 5'b11011;
    localparam logic [4:0] T_INCPC = 5'b11111;

    typedef struct packed {
        logic [4:0]  alu_op;
        logic [15:0] reg_in;
        logic [15:0] reg_out;
        logic pc_out, zlo_out, zhi_out, mdr_out;
        logic pc_in, mar_in, mdr_in, ir_in, y_in, zlo_in, zhi_in, hi_in, lo_in;
        logic rd, run;
    } ctl_t;

    logic        clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic [4:0]  alu_op;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic PCout, Zlowout, Zhighout, MDRout;
    logic PCin, MARin, MDRin, IRin, Yin, ZlowIn, ZhighIn, HIin, LOin;
    logic Read, run;
`ifdef ILLEGAL_TRAP_EN
    logic illegal_op;
`endif

    control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .ir        (ir),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .PCout     (PCout),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .MDRout    (MDRout),
        .PCin      (PCin),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .IRin      (IRin),
        .Yin       (Yin),
        .ZlowIn    (ZlowIn),
        .ZhighIn   (ZhighIn),
        .HIin      (HIin),
        .LOin      (LOin),
        .Read      (Read),
        .run       (run)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    ctl_t obs;
    assign obs = {alu_op, reg_in, reg_out, PCout, Zlowout, Zhighout, MDRout,
                  PCin, MARin, MDRin, IRin, Yin, ZlowIn, ZhighIn, HIin, LOin, Read, run};

    int   errors = 0;
    int   checks = 0;
    ctl_t expq[$];
    logic rdyq[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.run = 1'b1;
        return c;
    endfunction

    task automatic chk(input string tag, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle strobes for one whole instruction, built from the instruction's class.
    task automatic build(input logic [31:0] instr, input int w);
        logic [4:0] op;
        int ra, rb, rc;
        ctl_t c;
        op = instr[31:27];
        ra = int'(instr[26:23]);
        rb = int'(instr[22:19]);
        rc = int'(instr[18:15]);
        c = idle(); c.pc_out = 1; c.mar_in = 1; c.zlo_in = 1; c.alu_op = T_INCPC;
        expq.push_back(c); rdyq.push_back(1'($urandom));
        c = idle(); c.zlo_out = 1; c.pc_in = 1; c.rd = 1; c.mdr_in = 1;
        for (int k = 0; k <= w; k++) begin
            expq.push_back(c); rdyq.push_back(k == w);
        end
        c = idle(); c.mdr_out = 1; c.ir_in = 1;
        expq.push_back(c); rdyq.push_back(1'($urandom));
        if (op == T_ADD || op == T_SUB || op == T_AND || op == T_OR) begin
            c = idle(); c.reg_out = 16'(1) << rb; c.y_in = 1; expq.push_back(c);
            c = idle(); c.reg_out = 16'(1) << rc; c.zlo_in = 1; c.alu_op = op; expq.push_back(c);
            c = idle(); c.zlo_out = 1; c.reg_in = 16'(1) << ra; expq.push_back(c);
        end else if (op == T_NEG || op == T_NOT) begin
            c = idle(); c.reg_out = 16'(1) << rb; c.zlo_in = 1; c.alu_op = op; expq.push_back(c);
            c = idle(); c.zlo_out = 1; c.reg_in = 16'(1) << ra; expq.push_back(c);
        end else if (op == T_MUL || op == T_DIV) begin
            c = idle(); c.reg_out = 16'(1) << ra; c.y_in = 1; expq.push_back(c);
            c = idle(); c.reg_out = 16'(1) << rb; c.zlo_in = 1; c.zhi_in = 1; c.alu_op = op; expq.push_back(c);
            c = idle(); c.zlo_out = 1; c.lo_in = 1; expq.push_back(c);
            c = idle(); c.zhi_out = 1; c.hi_in = 1; expq.push_back(c);
        end else begin
            expq.push_back(idle());
        end
        while (rdyq.size() < expq.size()) rdyq.push_back(1'($urandom));
    endtask

    // Runs the modelled cycles, stopping after ncyc cycles when ncyc >= 0.
    task automatic run_instr(input logic [31:0] instr, input int w, input string tag, input int ncyc);
        int i;
        build(instr, w);
        i = 0;
        while (expq.size() > 0 && (ncyc < 0 || i < ncyc)) begin
            @(negedge clock);
            if (i == 0) ir = instr;
            mem_ready = rdyq.pop_front();
            chk($sformatf("%s[%0d]", tag, i), expq.pop_front());
            i++;
        end
        expq.delete();
        rdyq.delete();
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
    endfunction

    initial begin
        logic [31:0] instr;
        logic [4:0]  op;
        clear = 1'b0;
        mem_ready = 1'b0;
        ir = 32'h0;
        #1;
        chk("reset_async", idle());
        repeat (2) begin
            @(negedge clock);
            chk("reset_hold", idle());
        end
        clear = 1'b1;

        run_instr(32'h92800000, 0, "not_r5_r0", -1);
        run_instr(32'h8A800000, 0, "neg_r5_r0", -1);
        run_instr(mk(T_ADD, 1, 2, 3), 0, "add_r1_r2_r3", -1);
        run_instr(mk(T_SUB, 15, 0, 15), 3, "sub_wait3", -1);
        run_instr(mk(T_DIV, 7, 9, 0), 1, "div", -1);
        run_instr(mk(T_NOP, 4, 4, 4), 2, "nop", -1);
        run_instr(mk(5'b00000, 3, 3, 3), 0, "undef_op0", -1);
        run_instr(mk(T_INCPC, 1, 1, 1), 0, "undef_incpc", -1);

        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == T_HALT) op = T_MUL;
            instr = $urandom;
            instr[31:27] = op;
            run_instr(instr, int'($urandom_range(0, 3)), "rand", -1);
        end

        // Fetch (3 cycles) + T3 + T4 of a MUL, then clear while still in T4.
        run_instr(mk(T_MUL, 2, 6, 0), 0, "mul_cut", 5);
        #2 clear = 1'b0;
        #1 chk("clear_mid_t4", idle());
        @(negedge clock);
        chk("clear_held", idle());
        clear = 1'b1;
        run_instr(mk(T_OR, 12, 13, 14), 1, "or_after_clear", -1);

        run_instr(mk(T_HALT, 0, 0, 0), 0, "halt", -1);
        repeat (5) begin
            @(negedge clock);
            mem_ready = 1'($urandom);
            chk("halted", '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
